// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: controller for a folded FIR, one shared MAC stepping through all taps per sample
module fir_mac_sequencer #(
  parameter int TAPS = 102,
  parameter int MAC_LAT = 2,
  localparam int ADDR_W = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_smp_we,
  output logic              o_smp_wzero,
  output logic [ADDR_W-1:0] o_smp_waddr,
  output logic [ADDR_W-1:0] o_smp_raddr,
  output logic [ADDR_W-1:0] o_coef_addr,
  output logic              o_mac_en,
  output logic              o_mac_first,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy
);
  localparam int LAT_W = $clog2(MAC_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RUN, S_WAIT, S_HOLD} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_wr, r_rd, r_k;
  logic [LAT_W-1:0]  r_lat;
  logic              w_k_last;

  assign w_k_last = r_k == LAST;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_INIT;
    else r_state <= w_next;

  // next state and outputs decoded from state and counters; everything forced low during reset
  always_comb begin
    w_next = r_state;
    o_in_ready = 1'b0;
    o_smp_we = 1'b0;
    o_smp_wzero = 1'b0;
    o_smp_waddr = '0;
    o_smp_raddr = '0;
    o_coef_addr = '0;
    o_mac_en = 1'b0;
    o_mac_first = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      S_INIT: begin
        o_smp_we = 1'b1;
        o_smp_wzero = 1'b1;
        o_smp_waddr = r_k;
        w_next = w_k_last ? S_IDLE : S_INIT;
      end
      S_IDLE: begin
        o_in_ready = 1'b1;
        o_smp_we = i_in_valid;
        o_smp_waddr = r_wr;
        w_next = i_in_valid ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        o_mac_en = 1'b1;
        o_mac_first = r_k == '0;
        o_coef_addr = r_k;
        o_smp_raddr = r_rd;
        w_next = w_k_last ? S_WAIT : S_RUN;
      end
      S_WAIT: w_next = r_lat == LAT_W'(1) ? S_HOLD : S_WAIT;
      S_HOLD: begin
        o_out_valid = 1'b1;
        w_next = i_out_ready ? S_IDLE : S_HOLD;
      end
      default: w_next = S_INIT;
    endcase
    o_busy = r_state != S_IDLE;
    if (rst) begin
      {o_in_ready, o_smp_we, o_smp_wzero, o_mac_en, o_mac_first, o_out_valid, o_busy} = '0;
      {o_smp_waddr, o_smp_raddr, o_coef_addr} = '0;
    end
  end

  // write pointer, newest-first read pointer, tap index and MAC drain counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_k <= '0;
      r_lat <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_k <= w_k_last ? '0 : r_k + 1'b1;
          if (w_k_last) r_wr <= '0;
        end
        S_IDLE:
          if (i_in_valid) begin
            r_rd <= r_wr;
            r_wr <= r_wr == LAST ? '0 : r_wr + 1'b1;
            r_k <= '0;
          end
        S_RUN: begin
          r_k <= w_k_last ? '0 : r_k + 1'b1;
          r_rd <= r_rd == '0 ? LAST : r_rd - 1'b1;
          if (w_k_last) r_lat <= LAT_W'(MAC_LAT);
        end
        S_WAIT: r_lat <= r_lat - 1'b1;
        default: ;
      endcase
    end
endmodule
